// File: rtl/count_seq_ctrl.sv
// ============================================================================
// Module   : count_seq_ctrl
// Brief    : Run/pause/clear sequencer for the 4-bit display counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_ctrl #(
    parameter int TICK_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic       dir_sel,
    input  logic       oneshot,
    input  logic [3:0] load_val,
    input  logic [3:0] cnt_val,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       cnt_load,
    output logic [3:0] load_data,
    output logic       cnt_dir,
    output logic [1:0] state,
    output logic       done
);

    localparam int c_DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int c_PRE_W = $clog2(TICK_DIV);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Button index: 0 = start, 1 = pause, 2 = clear
    logic [2:0] w_raw;
    logic [2:0] w_press;

    assign w_raw = {btn_clear, btn_pause, btn_start};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_btn
            logic               sync1_q;
            logic               sync2_q;
            logic               lvl_q;
            logic               lvl_prev_q;
            logic [c_DEB_W-1:0] deb_q;

            always_ff @(posedge CLK) begin
                if (reset) begin
                    sync1_q    <= 1'b0;
                    sync2_q    <= 1'b0;
                    lvl_q      <= 1'b0;
                    lvl_prev_q <= 1'b0;
                    deb_q      <= '0;
                end else begin
                    sync1_q    <= w_raw[i];
                    sync2_q    <= sync1_q;
                    lvl_prev_q <= lvl_q;
                    if (sync2_q == lvl_q) begin
                        deb_q <= '0;
                    end else if (deb_q == c_DEB_LAST) begin
                        lvl_q <= sync2_q;
                        deb_q <= '0;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
            end

            assign w_press[i] = lvl_q & ~lvl_prev_q;
        end
    endgenerate

    // Only the highest-priority press in a cycle acts: clear > start > pause
    logic w_clr_act;
    logic w_start_act;
    logic w_pause_act;

    assign w_clr_act   = w_press[2];
    assign w_start_act = w_press[0] & ~w_press[2];
    assign w_pause_act = w_press[1] & ~w_press[0] & ~w_press[2];

    state_t             state_q;
    logic [c_PRE_W-1:0] presc_q;
    logic               cnt_en_q;
    logic               cnt_clr_q;
    logic               cnt_load_q;
    logic [3:0]         load_data_q;
    logic               cnt_dir_q;
    logic               done_q;

    logic w_tick;
    logic w_terminal;

    assign w_tick     = (presc_q == c_PRE_LAST);
    assign w_terminal = cnt_dir_q ? (cnt_val == 4'hF) : (cnt_val == 4'h0);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= 1'b0;
            cnt_load_q  <= 1'b0;
            load_data_q <= 4'h0;
            cnt_dir_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b0;
            cnt_load_q <= 1'b0;
            if (w_clr_act) begin
                cnt_clr_q <= 1'b1;
                state_q   <= ST_IDLE;
                presc_q   <= '0;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (w_start_act) begin
                            cnt_load_q  <= 1'b1;
                            load_data_q <= load_val;
                            cnt_dir_q   <= dir_sel;
                            presc_q     <= '0;
                            state_q     <= ST_RUN;
                            done_q      <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (w_tick) begin
                            presc_q <= '0;
                            if (w_terminal && oneshot) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_en_q <= 1'b1;
                                if (w_pause_act) begin
                                    state_q <= ST_PAUSED;
                                end
                            end
                        end else if (w_pause_act) begin
                            // Prescaler freezes so resume finishes the partial period
                            state_q <= ST_PAUSED;
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (w_start_act || w_pause_act) begin
                            state_q <= ST_RUN;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign cnt_load  = cnt_load_q;
    assign load_data = load_data_q;
    assign cnt_dir   = cnt_dir_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
- Run/pause/clear sequencer for the 4-bit display counter.
- Sits between the raw board buttons and the counter datapath.
- Debounces the buttons, generates the count-step enable from the system clock, and issues clear/load/enable/direction commands to the counter.
- Monitors the counter value to handle terminal count in wrap or one-shot mode.

Parameters:
- TICK_DIV, 100000: CLK cycles between count-enable pulses while running (min 2).
- DEB_CYCLES, 1000000: consecutive stable CLK samples needed to accept a button level change (min 1).

Ports:
- CLK  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- btn_start  input  1  raw start button, asynchronous, active-high.
- btn_pause  input  1  raw pause/resume button, asynchronous, active-high.
- btn_clear  input  1  raw clear button, asynchronous, active-high.
- dir_sel  input  1  1 = count up, 0 = count down; sampled only at start.
- oneshot  input  1  1 = stop at terminal count, 0 = wrap; sampled continuously.
- load_val  input  4  preset value for the counter.
- cnt_val  input  4  current counter value fed back from the datapath.
- cnt_en  output  1  one-cycle count-step pulse.
- cnt_clr  output  1  one-cycle clear pulse.
- cnt_load  output  1  one-cycle load pulse.
- load_data  output  4  value to load; valid while cnt_load is high.
- cnt_dir  output  1  latched direction (1 = up).
- state  output  2  IDLE=00, RUN=01, PAUSED=10, DONE=11.
- done  output  1  high while state is DONE.

Behaviour:
- Reset: CLK is the one clock. reset is synchronous and active-high; it takes priority over all other inputs. On reset:
  - state=IDLE; cnt_en=cnt_clr=cnt_load=0; load_data=0; cnt_dir=0; done=0.
  - Prescaler=0; debouncer counters=0; debounced levels=0.
- Button front end (each button):
  - 2-flop synchronizer, then debounce counter.
  - The debounce counter counts while the synced value differs from the stable level and zeroes when they match.
  - On reaching DEB_CYCLES, the stable level takes the synced value.
  - A rising edge of the stable level produces a 1-cycle press pulse.
  - Pulse appears DEB_CYCLES+2 to DEB_CYCLES+4 cycles after a clean raw edge.
  - Glitches shorter than DEB_CYCLES produce no pulse.
  - Holding a button produces exactly one pulse.
- Press priority in the same cycle: clear > start > pause. Only the highest-priority press acts.
- FSM (all outputs registered):
  - Any state, clear press: cnt_clr=1 for 1 cycle; go to IDLE; prescaler=0.
  - IDLE, start press: cnt_load=1 for 1 cycle; load_data=load_val; cnt_dir=dir_sel; prescaler=0; go to RUN.
  - IDLE, pause press: ignored.
  - RUN:
    - Prescaler increments every cycle.
    - When prescaler==TICK_DIV-1 there is a tick: prescaler=0.
    - Tick with cnt_val not terminal: cnt_en=1 for 1 cycle.
    - Tick with cnt_val terminal (F when cnt_dir=1, 0 when cnt_dir=0) and oneshot=0: cnt_en=1 (counter wraps).
    - Tick with cnt_val terminal and oneshot=1: no cnt_en; go to DONE.
    - Pause press: go to PAUSED; prescaler holds its value.
  - PAUSED:
    - No cnt_en.
    - Pause or start press: go to RUN; the prescaler resumes from its held value.
  - DONE:
    - done=1; no cnt_en.
    - Start press: behaves as IDLE start (load, latch direction, go to RUN).
    - Pause press: ignored.
- Tick coincident with a pause press: the tick's cnt_en is still issued and the state goes to PAUSED.
- Tick coincident with a clear press: the clear wins and no cnt_en is issued.
- Mid-operation reset: returns to the reset values above on the next edge, regardless of state.
- cnt_dir changes only on a start action; dir_sel changes at any other time are ignored.
- cnt_en, cnt_clr and cnt_load are mutually exclusive in every cycle.

Test Plan (TICK_DIV=4, DEB_CYCLES=2, bench counter model driven by controller outputs):
1. Reset, then start with load_val=3, dir_sel=1, oneshot=0 -> cnt_load pulses once with load_data=3; state=01; cnt_en pulses every 4 cycles; model counts 3,4,5...
2. Running up from E with oneshot=0 -> at F a cnt_en still issues; model wraps to 0; state stays 01.
3. dir_sel=0, load_val=2, oneshot=1, start -> model counts 2,1,0; next tick gives no cnt_en; state=11, done=1. A pause press here is ignored; a start press reloads 2 and returns to state 01.
4. Pause press in RUN mid-prescale -> state=10; no cnt_en for 50 cycles. Second pause press -> state 01; first cnt_en arrives after the remaining prescale count, not after a full 4.
5. Start and clear pressed in the same cycle in RUN -> only cnt_clr pulses; state=00; no cnt_load.
6. 1-cycle glitch on btn_start -> no press pulse. reset asserted in PAUSED -> all outputs 0, state=00 next cycle.
